vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_controller.sv | 162 ++++++++++++++++
 tb/tb_vend_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - soda vending controller: coin switch sync/edge detect, credit FSM, BCD display
// Nickels and dimes are counted on switch rising edges; dispensing and change are timed LED holds.
module vend_controller #(
  parameter int PRICE       = 25,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] n_sw,
  input  logic [2:0] d_sw,
  output logic [7:0] credit_bcd,
  output logic       soda_led,
  output logic       change_led,
  output logic       busy
);

  localparam int              TW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [6:0]      PRICE_C = 7'(PRICE);
  localparam logic [TW-1:0]   HOLD_C  = TW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [6:0]      credit;
  logic [6:0]      credit_nxt;
  logic [6:0]      change;
  logic [6:0]      change_nxt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_nxt;

  logic [4:0]      n_s1;
  logic [4:0]      n_s2;
  logic [4:0]      n_prev;
  logic [2:0]      d_s1;
  logic [2:0]      d_s2;
  logic [2:0]      d_prev;
  logic [1:0]      arm_cnt;
  logic            armed;
  logic [4:0]      n_rise;
  logic [2:0]      d_rise;
  logic [6:0]      coin_in;

  // Two-flop synchronizers plus the registered copy used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_s1    <= '0;
      n_s2    <= '0;
      n_prev  <= '0;
      d_s1    <= '0;
      d_s2    <= '0;
      d_prev  <= '0;
      arm_cnt <= '0;
    end else begin
      n_s1   <= n_sw;
      n_s2   <= n_s1;
      n_prev <= n_s2;
      d_s1   <= d_sw;
      d_s2   <= d_s1;
      d_prev <= d_s2;
      if (arm_cnt != 2'd3) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
    end
  end

  // Held off until the pipeline has refilled, so switches already high at release are not coins.
  assign armed   = (arm_cnt == 2'd3);
  assign n_rise  = armed ? (n_s2 & ~n_prev) : 5'd0;
  assign d_rise  = armed ? (d_s2 & ~d_prev) : 3'd0;
  assign coin_in = 7'd5 * 7'($countones(n_rise)) + 7'd10 * 7'($countones(d_rise));

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    change_nxt = change;
    timer_nxt  = timer;
    unique case (state)
      IDLE, COLLECT: begin
        if (credit >= PRICE_C) begin
          state_nxt  = VEND;
          change_nxt = credit - PRICE_C;
          credit_nxt = 7'd0;
          timer_nxt  = HOLD_C;
        end else begin
          credit_nxt = credit + coin_in;
          if (state == IDLE && credit != 7'd0) begin
            state_nxt = COLLECT;
          end
        end
      end
      VEND: begin
        if (timer <= TW'(1)) begin
          if (change != 7'd0) begin
            state_nxt = CHANGE;
            timer_nxt = HOLD_C;
          end else begin
            state_nxt = IDLE;
            timer_nxt = '0;
          end
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      CHANGE: begin
        if (timer <= TW'(1)) begin
          state_nxt  = IDLE;
          change_nxt = 7'd0;
          timer_nxt  = '0;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // LEDs and busy are registered from the next state so they track the state without decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      credit     <= '0;
      change     <= '0;
      timer      <= '0;
      soda_led   <= 1'b0;
      change_led <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      change     <= change_nxt;
      timer      <= timer_nxt;
      soda_led   <= (state_nxt == VEND);
      change_led <= (state_nxt == CHANGE);
      busy       <= (state_nxt == VEND) || (state_nxt == CHANGE);
    end
  end

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] r;
    tens = 4'd0;
    r    = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r    = r - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, r[3:0]};
  endfunction

  assign credit_bcd = to_bcd((state == VEND || state == CHANGE) ? change : credit);

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
// Runs with PRICE=25 and HOLD_CYCLES=10; inputs change on the falling edge, outputs sampled there too.
module tb_vend_controller;

  logic       clk;
  logic       rst_n;
  logic [4:0] n_sw;
  logic [2:0] d_sw;
  logic [7:0] credit_bcd;
  logic       soda_led;
  logic       change_led;
  logic       busy;

  int n_tests;
  int n_fail;

  logic [7:0]  bcd_h [64];
  logic [63:0] soda_h;
  logic [63:0] chg_h;
  logic [63:0] busy_h;

  vend_controller #(
    .PRICE      (25),
    .HOLD_CYCLES(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .n_sw      (n_sw),
    .d_sw      (d_sw),
    .credit_bcd(credit_bcd),
    .soda_led  (soda_led),
    .change_led(change_led),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_hist();
    soda_h = '0;
    chg_h  = '0;
    busy_h = '0;
    for (int i = 0; i < 64; i++) bcd_h[i] = 8'h00;
  endtask

  task automatic step_rec(input int k);
    step();
    bcd_h[k]  = credit_bcd;
    soda_h[k] = soda_led;
    chg_h[k]  = change_led;
    busy_h[k] = busy;
  endtask

  function automatic int bcd_count(input int a, input int b, input logic [7:0] v);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (bcd_h[i] === v) c++;
    return c;
  endfunction

  task automatic idle_gap();
    n_sw = 5'h00;
    d_sw = 3'b000;
    repeat (5) step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_sw    = 5'h00;
    d_sw    = 3'b111;
    rst_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_bcd", credit_bcd, 8'h00);
    check("reset_soda", soda_led, 1'b0);
    check("reset_change", change_led, 1'b0);
    check("reset_busy", busy, 1'b0);

    // Dimes held high through reset release must not count.
    rst_n = 1'b1;
    clear_hist();
    for (int k = 0; k < 30; k++) step_rec(k);
    check("held_bcd_zero", bcd_count(0, 29, 8'h00), 30);
    check("held_no_soda", $countones(soda_h), 0);
    check("held_no_busy", $countones(busy_h), 0);
    d_sw = 3'b000;
    repeat (5) step();
    check("falling_ignored", credit_bcd, 8'h00);

    // Three dimes at once: 30 cents, 5 change.
    clear_hist();
    d_sw = 3'b111;
    for (int k = 0; k < 26; k++) step_rec(k);
    check("d3_latency_bcd", bcd_h[1], 8'h00);
    check("d3_credit_bcd", bcd_h[2], 8'h30);
    check("d3_vend_bcd", bcd_h[3], 8'h05);
    check("d3_vend_start", soda_h[3], 1'b1);
    check("d3_soda_cycles", $countones(soda_h), 10);
    check("d3_soda_last", {soda_h[12], soda_h[13]}, 2'b10);
    check("d3_change_cycles", $countones(chg_h), 10);
    check("d3_change_bcd", bcd_h[13], 8'h05);
    check("d3_change_last", {chg_h[22], busy_h[22]}, 2'b11);
    check("d3_idle_bcd", bcd_h[23], 8'h00);
    check("d3_idle_busy", busy_h[23], 1'b0);
    idle_gap();

    // Nickels one at a time, exact price.
    clear_hist();
    for (int c = 0; c < 40; c++) begin
      if (c % 5 == 0 && c < 25) n_sw[c/5] = 1'b1;
      step_rec(c);
    end
    check("n_05", bcd_h[2], 8'h05);
    check("n_05_hold", bcd_h[6], 8'h05);
    check("n_10", bcd_h[7], 8'h10);
    check("n_15", bcd_h[12], 8'h15);
    check("n_20", bcd_h[17], 8'h20);
    check("n_25", bcd_h[22], 8'h25);
    check("n_vend", {soda_h[23], bcd_h[23]}, {1'b1, 8'h00});
    check("n_soda_cycles", $countones(soda_h), 10);
    check("n_no_change", $countones(chg_h), 0);
    check("n_idle", {busy_h[32], busy_h[33]}, 2'b10);
    idle_gap();

    // All eight switches at once: 55 cents, 30 change.
    clear_hist();
    n_sw = 5'h1f;
    d_sw = 3'b111;
    for (int k = 0; k < 26; k++) step_rec(k);
    check("all_credit", bcd_h[2], 8'h55);
    check("all_change_bcd", bcd_count(3, 22, 8'h30), 20);
    check("all_soda_cycles", $countones(soda_h), 10);
    check("all_change_cycles", $countones(chg_h), 10);
    check("all_idle_bcd", bcd_h[23], 8'h00);
    idle_gap();

    // A dime toggled while vending is discarded.
    clear_hist();
    n_sw = 5'h1f;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) d_sw[0] = 1'b1;
      if (k == 8) d_sw[0] = 1'b0;
      step_rec(k);
    end
    check("tog_credit", bcd_h[2], 8'h25);
    check("tog_soda_cycles", $countones(soda_h), 10);
    check("tog_no_change", $countones(chg_h), 0);
    check("tog_idle_bcd", bcd_count(13, 19, 8'h00), 7);
    check("tog_idle_busy", busy_h[13], 1'b0);
    idle_gap();

    // Reset pulsed in the middle of returning change.
    clear_hist();
    d_sw = 3'b111;
    for (int k = 0; k < 15; k++) step_rec(k);
    check("mid_in_change", {chg_h[14], bcd_h[14]}, {1'b1, 8'h05});
    rst_n = 1'b0;
    #1;
    check("mid_rst_bcd", credit_bcd, 8'h00);
    check("mid_rst_leds", {soda_led, change_led, busy}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_hist();
    for (int k = 0; k < 20; k++) step_rec(k);
    check("mid_after_busy", $countones(busy_h), 0);
    check("mid_after_leds", $countones(soda_h | chg_h), 0);
    check("mid_after_bcd", bcd_count(0, 19, 8'h00), 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
